// File: rtl/div_nnbit_s01_abs_itera.sv
// Iterative restoring divider, one quotient bit per clock, operating on operand
// magnitudes with sign correction of quotient and remainder at completion.
module div_nnbit_s01_abs_itera #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_valid
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    dvd;     // dividend magnitude, quotient bits shift in at the LSB
  logic [W-1:0]    dvs;     // divisor magnitude
  logic [W-1:0]    prem;    // partial remainder between steps
  logic            neg_q;
  logic            neg_r;
  logic            y_zero;

  logic [W-1:0]    abs_x_c;
  logic [W-1:0]    abs_y_c;
  logic [W:0]      part_c;
  logic            take_c;
  logic [W-1:0]    diff_c;
  logic [W-1:0]    prem_nx_c;
  logic [W-1:0]    dvd_nx_c;
  logic [W-1:0]    q_fix_c;
  logic [W-1:0]    r_fix_c;

  // Operand magnitudes; the most negative pattern maps to 2^(W-1) unsigned
  always_comb begin
    abs_x_c = i_num_x;
    abs_y_c = i_num_y;
    if (i_signed && i_num_x[W-1]) abs_x_c = W'(~i_num_x + W'(1));
    if (i_signed && i_num_y[W-1]) abs_y_c = W'(~i_num_y + W'(1));
  end

  // One restoring step; the W-bit difference is exact whenever the trial succeeds
  always_comb begin
    part_c    = {prem, dvd[W-1]};
    take_c    = (part_c >= {1'b0, dvs});
    diff_c    = W'(part_c[W-1:0] - dvs);
    prem_nx_c = take_c ? diff_c : part_c[W-1:0];
    dvd_nx_c  = {dvd[W-2:0], take_c};
    q_fix_c   = dvd_nx_c;
    r_fix_c   = prem_nx_c;
    if (y_zero)     q_fix_c = '1;
    else if (neg_q) q_fix_c = W'(~dvd_nx_c + W'(1));
    if (neg_r)      r_fix_c = W'(~prem_nx_c + W'(1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      y_zero  <= 1'b0;
      o_res   <= '0;
      o_rem   <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_valid) begin
            dvd    <= abs_x_c;
            dvs    <= abs_y_c;
            prem   <= '0;
            cnt    <= CW'(W);
            neg_q  <= i_signed & (i_num_x[W-1] ^ i_num_y[W-1]);
            neg_r  <= i_signed & i_num_x[W-1];
            y_zero <= (i_num_y == '0);
            state  <= CALC;
          end
        end
        CALC: begin
          dvd  <= dvd_nx_c;
          prem <= prem_nx_c;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_res   <= q_fix_c;
            o_rem   <= r_fix_c;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_nnbit_s01_abs_itera.sv
// Directed self-checking bench for the iterative abs-value divider (DATA_WIDTH=8).
module tb_div_nnbit_s01_abs_itera;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic       sgn;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] res;
  logic [7:0] rem;
  logic       ov;

  int n_checks = 0;
  int n_fail   = 0;

  div_nnbit_s01_abs_itera #(.DATA_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_signed(sgn),
    .i_num_x (x),
    .i_num_y (y),
    .o_res   (res),
    .o_rem   (rem),
    .o_valid (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one divide, scramble inputs after accept, return negedge count to o_valid
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    sgn = s; x = a; y = b; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; x = ~a; y = 8'h00; sgn = ~s;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (ov) lat = k;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; sgn = 1'b0; x = 8'h00; y = 8'h00;
    #1;
    n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL reset_res got %h exp 00", res); end
    n_checks++; if (rem !== 8'h00) begin n_fail++; $display("FAIL reset_rem got %h exp 00", rem); end
    n_checks++; if (ov !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b exp 0", ov); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic       vs [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] vx [10] = '{8'h95, 8'h95, 8'h64, 8'h9C, 8'h64, 8'h95, 8'h10, 8'h80, 8'h80, 8'hFF};
    logic [7:0] vy [10] = '{8'h1D, 8'h1D, 8'hF9, 8'hF9, 8'h07, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10};
    logic [7:0] vq [10] = '{8'hFD, 8'h05, 8'hF2, 8'h0E, 8'h0E, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h0F};
    logic [7:0] vr [10] = '{8'hEC, 8'h04, 8'h02, 8'hFE, 8'h02, 8'h95, 8'h10, 8'h00, 8'h80, 8'h0F};
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(vs[i], vx[i], vy[i], lat);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL vec%0d_latency got %0d exp 9", i, lat); end
      n_checks++;
      if (res !== vq[i]) begin n_fail++; $display("FAIL vec%0d_res got %h exp %h", i, res, vq[i]); end
      n_checks++;
      if (rem !== vr[i]) begin n_fail++; $display("FAIL vec%0d_rem got %h exp %h", i, rem, vr[i]); end
      @(negedge clk);
      n_checks++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL vec%0d_pulse_width got %b exp 0", i, ov); end
    end
  endtask

  task automatic test_hold;
    repeat (5) begin
      @(negedge clk);
      x = 8'h5A; y = 8'h03; sgn = 1'b1;
    end
    n_checks++; if (res !== 8'h0F) begin n_fail++; $display("FAIL hold_res got %h exp 0F", res); end
    n_checks++; if (rem !== 8'h0F) begin n_fail++; $display("FAIL hold_rem got %h exp 0F", rem); end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int last = 0;
    sgn = 1'b1; x = 8'h95; y = 8'h1D;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (ov) begin
        n_checks++;
        if (res !== 8'hFD) begin n_fail++; $display("FAIL b2b_res got %h exp FD", res); end
        n_checks++;
        if (rem !== 8'hEC) begin n_fail++; $display("FAIL b2b_rem got %h exp EC", rem); end
        n_checks++;
        if (pulses == 0) begin
          if (k !== 9) begin n_fail++; $display("FAIL b2b_first_pulse got %0d exp 9", k); end
        end else begin
          if (k - last !== 10) begin n_fail++; $display("FAIL b2b_period got %0d exp 10", k - last); end
        end
        last = k;
        pulses++;
      end
      valid = ~ov;
    end
    valid = 1'b0;
    n_checks++;
    if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulse_count got %0d exp 3", pulses); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int seen = 0;
    int lat;
    @(negedge clk);
    sgn = 1'b1; x = 8'h95; y = 8'h1D; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL midrst_res got %h exp 00", res); end
    n_checks++; if (rem !== 8'h00) begin n_fail++; $display("FAIL midrst_rem got %h exp 00", rem); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_valid got %0d pulses exp 0", seen); end
    run_op(1'b0, 8'h95, 8'h1D, lat);
    n_checks++; if (lat !== 9)     begin n_fail++; $display("FAIL midrst_latency got %0d exp 9", lat); end
    n_checks++; if (res !== 8'h05) begin n_fail++; $display("FAIL midrst_res_after got %h exp 05", res); end
    n_checks++; if (rem !== 8'h04) begin n_fail++; $display("FAIL midrst_rem_after got %h exp 04", rem); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
